// File: rtl/abro_input_conditioner.sv
// Conditions the raw asynchronous A/B request lines into debounced levels and one-cycle rise pulses.
// Each channel is a two-flop synchronizer followed by a LOW/RISE_CHK/HIGH/FALL_CHK debounce FSM.
module abro_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_raw,
  output logic       o_pulse,
  output logic       o_level,
  output logic [1:0] o_state
);
  localparam logic [1:0] ST_LOW      = 2'b00;
  localparam logic [1:0] ST_RISE_CHK = 2'b01;
  localparam logic [1:0] ST_HIGH     = 2'b10;
  localparam logic [1:0] ST_FALL_CHK = 2'b11;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (r_sync2) begin
            r_state <= ST_RISE_CHK;
            r_cnt   <= LP_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_RISE_CHK: begin
          if (!r_sync2) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!r_sync2) begin
            r_state <= ST_FALL_CHK;
            r_cnt   <= LP_CNT_ONE;
          end
        end
        ST_FALL_CHK: begin
          // A confirmed fall returns to LOW silently; only rises pulse.
          if (r_sync2) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_state[1];
  assign o_state = r_state;
endmodule

module abro_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  output logic       a_pulse,
  output logic       b_pulse,
  output logic       a_level,
  output logic       b_level,
  output logic [1:0] a_state,
  output logic [1:0] b_state
);
  // Identical, independent channels so simultaneous confirmed rises pulse in the same cycle.
  abro_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_raw  (raw_a),
    .o_pulse(a_pulse),
    .o_level(a_level),
    .o_state(a_state)
  );

  abro_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_raw  (raw_b),
    .o_pulse(b_pulse),
    .o_level(b_level),
    .o_state(b_state)
  );
endmodule

// File: doc/abro_input_conditioner.md
# abro_input_conditioner

Front-end stage for the ABRO state machine: takes the two raw, asynchronous A/B request lines and turns each into a clean, single-cycle rising-edge pulse that drives the state machine's A and B inputs. Each channel has a two-flop synchronizer, then a debounce FSM that confirms a level change only after it has been stable for DEBOUNCE_CYCLES consecutive samples. The two channels are identical and independent, so simultaneous confirmed rises give same-cycle pulses. That is the event the ABRO state machine needs for its direct A&&B transition.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive synchronized samples required to confirm a level change; legal range 2..255.
- CNT_W, default 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; forces every register to its reset value immediately.
- raw_a  input  1  raw A request, asynchronous to clk, may bounce.
- raw_b  input  1  raw B request, asynchronous to clk, may bounce.
- a_pulse  output  1  registered one-cycle pulse on a confirmed A rise; connects to the state machine's A input.
- b_pulse  output  1  registered one-cycle pulse on a confirmed B rise; connects to the state machine's B input.
- a_level  output  1  debounced A level.
- b_level  output  1  debounced B level.
- a_state  output  2  channel-A debounce FSM state, for debug.
- b_state  output  2  channel-B debounce FSM state, for debug.

## Operation
- Synchronizer per channel: raw_x goes into sync1, sync1 goes into sync2, and sync2 is the sample s_x. Raw inputs are never used anywhere else.
- Debounce FSM per channel, with encodings LOW=2'b00, RISE_CHK=2'b01, HIGH=2'b10, FALL_CHK=2'b11:
  - LOW: if s=1, go to RISE_CHK with cnt<=1; otherwise stay, with cnt<=0.
  - RISE_CHK:
    - If s=0, go to LOW with cnt<=0 (glitch rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HIGH with cnt<=0, and the pulse register sets for one cycle.
    - Otherwise cnt<=cnt+1.
  - HIGH: if s=0, go to FALL_CHK with cnt<=1; otherwise stay.
  - FALL_CHK:
    - If s=1, go to HIGH with cnt<=0, no pulse.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to LOW with cnt<=0.
    - Otherwise cnt<=cnt+1.
    - A confirmed fall produces no pulse.
- x_level is 1 in HIGH and FALL_CHK, and 0 in LOW and RISE_CHK. It is decoded from the registered state.
- x_pulse is a register, set only on the RISE_CHK-to-HIGH edge and cleared on the next edge. Its maximum width is 1 cycle.
- The counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Channels share no state. a_pulse and b_pulse may assert in the same cycle, in either order, or in different cycles.

## Timing
- Reset values (asserted, and immediately after release):
  - sync1 = sync2 = 0, state = LOW, cnt = 0.
  - a_pulse = b_pulse = 0, a_level = b_level = 0, a_state = b_state = 2'b00.
- Rise latency, counting edge 0 as the first edge at which raw_x is captured high and held stable:
  - s_x is high after edge 1.
  - RISE_CHK is entered at edge 2.
  - HIGH is entered and x_pulse sets at edge DEBOUNCE_CYCLES+1.
  - x_pulse is high for exactly the one cycle between edges DEBOUNCE_CYCLES+1 and DEBOUNCE_CYCLES+2.
  - For the default DEBOUNCE_CYCLES=4: pulse high between edges 5 and 6.
- Fall latency follows the same timing: x_level drops after edge DEBOUNCE_CYCLES+1.
- Minimum accepted high time: DEBOUNCE_CYCLES consecutive synchronized samples. Anything shorter yields no pulse and no level change.
- Raw input already high at reset release: treated as a fresh rise. One pulse is produced DEBOUNCE_CYCLES+2 edges after release.
- Reset asserted mid-count or mid-pulse:
  - Everything clears asynchronously.
  - A pulse in flight is truncated.
  - No pulse is produced on release unless the input then qualifies again from LOW.
- Held-high input: exactly one pulse per confirmed rise, regardless of how long the input stays high.

## Test plan
- Reset: hold reset=0 with raw_a=raw_b=0 for 3 cycles, then release. Required: all outputs 0 and both states 2'b00 for 10 cycles.
- Clean rise, DEBOUNCE_CYCLES=4: raw_a rises before edge 0 and stays high. Required: a_pulse=1 only between edges 5 and 6, a_level=1 from edge 5 on, b outputs stay 0.
- Glitch rejection: raw_b high for 3 cycles, then low. Required: b_state goes 00 to 01 and back to 00, b_pulse never asserts, b_level stays 0. Repeat with raw_b high for 4 cycles. Required: one b_pulse.
- Simultaneous: raw_a and raw_b rise in the same cycle. Required: a_pulse and b_pulse both 1 in the same single cycle, the same-cycle A&&B condition the state machine consumes.
- Bounce then fall: raw_a toggles 1,0,1,1,1,1, then stays high for 20 cycles, then low. Required: one a_pulse, a_level=1 until DEBOUNCE_CYCLES+2 edges after the final fall, no pulse on the fall.
- Reset mid-operation: assert reset while a_state=01 with cnt=2 and raw_a still high. Required: immediate clear. After release, exactly one a_pulse at edge DEBOUNCE_CYCLES+2 after release.
